// File: rtl/tc_to_sm_converter_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : tc_to_sm_converter_stream_if
// Purpose  : Input/output stream bundle for the two's-complement to
//            sign-magnitude drain converter. Carries the valid/ready input
//            side and the valid/ready output side.
// Revision : 1.0 - initial release
// ============================================================================
interface tc_to_sm_converter_stream_if #(
  parameter int IN_W  = 9,
  parameter int MAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [MAG_W-1:0] out_mag;
  logic             out_sat;
  logic             out_last;

  // Producer/consumer side: drives input data and output ready
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_sat, out_last
  );

  // Converter side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_sat, out_last
  );
endinterface
`default_nettype wire

// File: rtl/tc_to_sm_converter_stream.sv
`default_nettype none
// ============================================================================
// Module   : tc_to_sm_converter_stream
// Purpose  : Streaming two's-complement -> sign-magnitude decoder for the
//            systolic array drain. Two-stage pipeline (S1: sign/abs,
//            S2: saturate/register outputs) with full-throughput
//            backpressure and a sticky saturation event counter.
// Revision : 1.0 - initial release
// ============================================================================
module tc_to_sm_converter_stream #(
  parameter int IN_W  = 9,
  parameter int MAG_W = 8,
  parameter int CNT_W = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  tc_to_sm_converter_stream_if.slave bus,
  input  wire logic                 clr_cnt,
  output logic [CNT_W-1:0]          sat_cnt
);

  localparam logic [IN_W:0]    c_one      = {{IN_W{1'b0}}, 1'b1};
  localparam logic [MAG_W-1:0] c_mag_max  = {MAG_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [IN_W:0]    s1_abs_q,   s1_abs_d;
  logic             s1_last_q,  s1_last_d;

  // Stage 2 (output) state
  logic             out_valid_q, out_valid_d;
  logic             out_sign_q,  out_sign_d;
  logic [MAG_W-1:0] out_mag_q,   out_mag_d;
  logic             out_sat_q,   out_sat_d;
  logic             out_last_q,  out_last_d;

  logic [CNT_W-1:0] sat_cnt_q,   sat_cnt_d;

  // Combinational helpers
  logic             s2_en;
  logic             s1_en;
  logic             in_xfer;
  logic             out_xfer;
  logic [IN_W:0]    in_ext;
  logic [IN_W:0]    in_abs;
  logic             s1_sat;

  // Pipeline enables: a stage may load when it is empty or its contents move on
  always_comb begin
    s2_en    = !out_valid_q || bus.out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_xfer  = bus.in_valid && s1_en;
    out_xfer = out_valid_q && bus.out_ready;
  end

  // Absolute value at IN_W+1 bits so the most negative input negates exactly
  always_comb begin
    in_ext = {bus.in_data[IN_W-1], bus.in_data};
    in_abs = bus.in_data[IN_W-1] ? (~in_ext + c_one) : in_ext;
    // Any set bit at or above MAG_W means the magnitude does not fit
    s1_sat = |s1_abs_q[IN_W:MAG_W];
  end

  // Stage 1 next state: capture sign/abs/last on an accepted input
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_abs_d   = s1_abs_q;
    s1_last_d  = s1_last_q;
    if (s1_en) begin
      s1_valid_d = bus.in_valid;
    end
    if (in_xfer) begin
      s1_sign_d = bus.in_data[IN_W-1];
      s1_abs_d  = in_abs;
      s1_last_d = bus.in_last;
    end
  end

  // Stage 2 next state: outputs change only when a valid S1 element advances
  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_mag_d   = out_mag_q;
    out_sat_d   = out_sat_q;
    out_last_d  = out_last_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d = s1_sign_q;
        out_mag_d  = s1_sat ? c_mag_max : s1_abs_q[MAG_W-1:0];
        out_sat_d  = s1_sat;
        out_last_d = s1_last_q;
      end
    end
  end

  // Saturation counter: clear wins, otherwise count saturated output transfers
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_cnt) begin
      sat_cnt_d = '0;
    end else if (out_xfer && out_sat_q && (sat_cnt_q != c_cnt_max)) begin
      sat_cnt_d = sat_cnt_q + c_cnt_one;
    end
  end

  // State registers with synchronous reset discarding any in-flight elements
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_abs_q    <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_mag_q   <= '0;
      out_sat_q   <= 1'b0;
      out_last_q  <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_abs_q    <= s1_abs_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_mag_q   <= out_mag_d;
      out_sat_q   <= out_sat_d;
      out_last_q  <= out_last_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_last  = out_last_q;
  assign sat_cnt       = sat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tc_to_sm_converter_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_to_sm_converter_stream
// Purpose  : Self-checking bench for tc_to_sm_converter_stream. Directed
//            vector table plus randomized streams scored against a
//            behavioural sign-magnitude reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_to_sm_converter_stream;

  localparam int IN_W  = 9;
  localparam int MAG_W = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MAG_MAX = (1 << MAG_W) - 1;

  typedef struct {
    logic [IN_W-1:0]  din;
    logic             last;
    logic             sgn;
    logic [MAG_W-1:0] mag;
    logic             sat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] sat_cnt;

  always #5 clk = ~clk;

  tc_to_sm_converter_stream_if #(.IN_W(IN_W), .MAG_W(MAG_W)) bus ();

  tc_to_sm_converter_stream #(.IN_W(IN_W), .MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .sat_cnt (sat_cnt)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   cnt_m = 0;
  int   last_seen = 0;
  logic in_x = 1'b0;
  logic out_x = 1'b0;
  logic lat_chk = 1'b0;
  logic prev_stall = 1'b0;
  logic ps_sign, ps_sat, ps_last;
  logic [MAG_W-1:0] ps_mag;
  vec_t q[$];
  int   tq[$];
  vec_t nil;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion straight from arithmetic on the signed value
  function automatic vec_t model(input logic [IN_W-1:0] d, input logic l);
    vec_t v;
    int x, a;
    x = $signed(d);
    a = (x < 0) ? -x : x;
    v.din  = d;
    v.last = l;
    v.sgn  = (x < 0);
    v.sat  = (a > MAG_MAX);
    v.mag  = v.sat ? MAG_MAX[MAG_W-1:0] : a[MAG_W-1:0];
    return v;
  endfunction

  // One clock: evaluate transfers just after the negedge drive, then advance
  task automatic step(input vec_t e);
    vec_t f;
    int   t;
    logic f_sat;
    #1;
    f_sat = 1'b0;
    in_x  = 1'b0;
    out_x = 1'b0;
    if (rst) begin
      q.delete();
      tq.delete();
      cnt_m = 0;
      prev_stall = 1'b0;
    end else begin
      chk("sat_cnt", sat_cnt, cnt_m);
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_sign", bus.out_sign, ps_sign);
        chk("stall_mag", bus.out_mag, ps_mag);
        chk("stall_sat", bus.out_sat, ps_sat);
        chk("stall_last", bus.out_last, ps_last);
      end
      out_x = bus.out_valid && bus.out_ready;
      in_x  = bus.in_valid && bus.in_ready;
      if (out_x) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got mag %0h with empty scoreboard", bus.out_mag);
        end else begin
          f = q.pop_front();
          t = tq.pop_front();
          f_sat = f.sat;
          chk("out_sign", bus.out_sign, f.sgn);
          chk("out_mag", bus.out_mag, f.mag);
          chk("out_sat", bus.out_sat, f.sat);
          chk("out_last", bus.out_last, f.last);
          if (lat_chk) chk("latency", cyc - t, 2);
          if (bus.out_last) last_seen++;
        end
      end
      if (clr_cnt) cnt_m = 0;
      else if (out_x && f_sat && cnt_m < CNT_MAX) cnt_m++;
      if (in_x) begin
        q.push_back(e);
        tq.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      ps_sign = bus.out_sign;
      ps_mag  = bus.out_mag;
      ps_sat  = bus.out_sat;
      ps_last = bus.out_last;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && (q.size() != 0 || bus.out_valid); k++) step(nil);
    if (q.size() != 0 || bus.out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d elements still pending", q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    logic [IN_W-1:0] d;
    logic l;
    logic need_new;
    int acc;

    nil = '{din: '0, last: 1'b0, sgn: 1'b0, mag: '0, sat: 1'b0};
    tbl[0] = '{din: 9'h005, last: 1'b0, sgn: 1'b0, mag: 8'd5,   sat: 1'b0};
    tbl[1] = '{din: 9'h1FB, last: 1'b0, sgn: 1'b1, mag: 8'd5,   sat: 1'b0};
    tbl[2] = '{din: 9'h000, last: 1'b0, sgn: 1'b0, mag: 8'd0,   sat: 1'b0};
    tbl[3] = '{din: 9'h0FF, last: 1'b0, sgn: 1'b0, mag: 8'd255, sat: 1'b0};
    tbl[4] = '{din: 9'h101, last: 1'b0, sgn: 1'b1, mag: 8'd255, sat: 1'b0};
    tbl[5] = '{din: 9'h100, last: 1'b1, sgn: 1'b1, mag: 8'd255, sat: 1'b1};
    tbl[6] = '{din: 9'h0FE, last: 1'b0, sgn: 1'b0, mag: 8'd254, sat: 1'b0};
    tbl[7] = '{din: 9'h1FF, last: 1'b0, sgn: 1'b1, mag: 8'd1,   sat: 1'b0};
    tbl[8] = '{din: 9'h180, last: 1'b0, sgn: 1'b1, mag: 8'd128, sat: 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    step(nil);
    step(nil);
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sign", bus.out_sign, 0);
    chk("rst_out_mag", bus.out_mag, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Directed table, back to back, fixed two-cycle latency
    lat_chk = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = tbl[i].din;
      bus.in_last  = tbl[i].last;
      chk("table_in_ready", bus.in_ready, 1);
      step(tbl[i]);
    end
    drain();
    chk("table_sat_cnt", sat_cnt, 1);
    lat_chk = 1'b0;

    // Random stream, out_ready toggling every cycle
    need_new = 1'b1;
    d = '0;
    l = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (need_new) begin
        d = ($urandom_range(0, 7) == 0) ? 9'h100 : 9'($urandom);
        l = 1'($urandom_range(0, 1));
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.out_ready = (i % 2 == 0);
      step(model(d, l));
      need_new = in_x;
    end
    drain();

    // Stall from empty: exactly two elements fit before in_ready falls
    acc = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 9'($urandom);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = 1'b0;
      step(model(d, 1'b0));
      if (in_x) acc++;
    end
    chk("stall_accepts", acc, 2);
    chk("stall_in_ready", bus.in_ready, 0);
    drain();

    // Frame of four with in_last on the fourth, random stalls
    last_seen = 0;
    for (int i = 0; i < 4; i++) begin
      d = 9'($urandom);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = (i == 3);
      for (int k = 0; k < 20; k++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        step(model(d, i == 3));
        if (in_x) break;
      end
      if (!in_x) chk("frame_accept_timeout", 0, 1);
    end
    drain();
    chk("frame_last_count", last_seen, 1);

    // Saturation counter sticks at its maximum
    clr_cnt = 1'b1;
    step(nil);
    clr_cnt = 1'b0;
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 9'h100;
      bus.in_last  = 1'b0;
      step(model(9'h100, 1'b0));
    end
    drain();
    chk("sat_cnt_sticky", sat_cnt, CNT_MAX);

    // Clear coinciding with a saturated output transfer
    bus.in_valid = 1'b1;
    bus.in_data  = 9'h100;
    step(model(9'h100, 1'b0));
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && !bus.out_valid; k++) step(nil);
    chk("clr_pending_sat", bus.out_sat, 1);
    clr_cnt = 1'b1;
    step(nil);
    clr_cnt = 1'b0;
    chk("clr_priority", sat_cnt, 0);

    // Mid-stream reset with both stages full
    bus.in_valid = 1'b1;
    bus.in_data  = 9'h100;
    step(model(9'h100, 1'b0));
    drain();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 9'h181;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = 1'b1;
      step(model(d, 1'b1));
    end
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    step(nil);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_sat_cnt", sat_cnt, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_mag", bus.out_mag, 0);
    chk("midrst_out_last", bus.out_last, 0);

    // First element after reset arrives two cycles after acceptance
    lat_chk = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 9'h1F0;
    bus.in_last   = 1'b0;
    step(model(9'h1F0, 1'b0));
    drain();
    lat_chk = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
